// File: rtl/decode_pkg.sv
// decode_pkg: RV32I decode constants, immediate formats and stage states.
package decode_pkg;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;
  typedef enum logic {ST_RUN, ST_SQUASH} state_e;
  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    return (op == OP_IMM || op == LOAD || op == JALR) ? IMM_I :
           (op == STORE)                              ? IMM_S :
           (op == BRANCH)                             ? IMM_B :
           (op == LUI || op == AUIPC)                 ? IMM_U :
           (op == JAL)                                ? IMM_J : IMM_NONE;
  endfunction
  // 32-bit signed immediate; callers sign-extend to XLEN with a size cast
  function automatic logic signed [31:0] imm32(input logic [31:0] inst);
    imm_fmt_e f;
    f = imm_fmt(inst[6:0]);
    return (f == IMM_I) ? {{20{inst[31]}}, inst[31:20]} :
           (f == IMM_S) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
           (f == IMM_B) ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
           (f == IMM_U) ? {inst[31:12], 12'b0} :
           (f == IMM_J) ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                          32'sd0;
  endfunction
endpackage

// File: rtl/decode_stage_pipe_regfile.sv
// regfile_2r1w: two async read ports, one write port, x0 hardwired to zero.
// Optional same-cycle write-through forwarding under DECODE_WB_BYPASS_EN.
module regfile_2r1w #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int REG_W   = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_w_en,
  input  logic [REG_W-1:0] i_w_rd_num,
  input  logic [XLEN-1:0]  i_w_rd,
  input  logic [REG_W-1:0] i_rs_1_num,
  input  logic [REG_W-1:0] i_rs_2_num,
  output logic [XLEN-1:0]  o_rs_1,
  output logic [XLEN-1:0]  o_rs_2
);
  logic [XLEN-1:0] r_regs [REG_NUM];
  logic [XLEN-1:0] w_rd_1, w_rd_2;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    else if (i_w_en && i_w_rd_num != '0 && 32'(i_w_rd_num) < REG_NUM)
      r_regs[i_w_rd_num] <= i_w_rd;
  assign w_rd_1 = (i_rs_1_num == '0 || 32'(i_rs_1_num) >= REG_NUM) ? '0 : r_regs[i_rs_1_num];
  assign w_rd_2 = (i_rs_2_num == '0 || 32'(i_rs_2_num) >= REG_NUM) ? '0 : r_regs[i_rs_2_num];
`ifdef DECODE_WB_BYPASS_EN
  assign o_rs_1 = (i_w_en && i_w_rd_num == i_rs_1_num && i_rs_1_num != '0) ? i_w_rd : w_rd_1;
  assign o_rs_2 = (i_w_en && i_w_rd_num == i_rs_2_num && i_rs_2_num != '0) ? i_w_rd : w_rd_2;
`else
  assign o_rs_1 = w_rd_1;
  assign o_rs_2 = w_rd_2;
`endif
endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered RV32I decode stage with regfile, load-use stall and branch squash.
// Build option DECODE_WB_BYPASS_EN enables writeback-to-read forwarding in the register file.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int REG_W   = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [31:0]      i_inst,
  input  logic [XLEN-1:0]  i_pc,
  output logic             o_ready,
  input  logic             i_w_en,
  input  logic [REG_W-1:0] i_w_rd_num,
  input  logic [XLEN-1:0]  i_w_rd,
  input  logic             i_ex_ready,
  input  logic             i_ex_is_load,
  input  logic [REG_W-1:0] i_ex_rd_num,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_rs_1,
  output logic [XLEN-1:0]  o_rs_2,
  output logic [REG_W-1:0] o_rd_num,
  output logic [6:0]       o_opcode,
  output logic [2:0]       o_func_3,
  output logic [6:0]       o_func_7,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_b_taken,
  output logic [XLEN-1:0]  o_b_pc
);
  state_e r_state, w_state_nxt;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [REG_W-1:0] w_rs_1_num, w_rs_2_num;
  logic [XLEN-1:0] w_rs_1, w_rs_2, w_imm, w_b_pc;
  logic w_uses_rs_1, w_uses_rs_2, w_hazard, w_hold, w_fire;
  logic w_eq, w_lt, w_ltu, w_cond, w_taken;
  logic r_valid, r_b_taken;
  logic [XLEN-1:0] r_rs_1, r_rs_2, r_imm, r_b_pc;
  logic [REG_W-1:0] r_rd_num;
  logic [6:0] r_opcode, r_func_7;
  logic [2:0] r_func_3;
  assign w_op       = i_inst[6:0];
  assign w_f3       = i_inst[14:12];
  assign w_rs_1_num = REG_W'(i_inst[19:15]);
  assign w_rs_2_num = REG_W'(i_inst[24:20]);
  assign w_imm      = XLEN'(imm32(i_inst));
  regfile_2r1w #(.XLEN(XLEN), .REG_NUM(REG_NUM), .REG_W(REG_W)) u_rf (
    .i_clk(i_clk), .i_rst(i_rst), .i_w_en(i_w_en), .i_w_rd_num(i_w_rd_num), .i_w_rd(i_w_rd),
    .i_rs_1_num(w_rs_1_num), .i_rs_2_num(w_rs_2_num), .o_rs_1(w_rs_1), .o_rs_2(w_rs_2)
  );
  assign w_uses_rs_1 = w_op == OP || w_op == OP_IMM || w_op == LOAD || w_op == STORE ||
                       w_op == BRANCH || w_op == JALR;
  assign w_uses_rs_2 = w_op == OP || w_op == STORE || w_op == BRANCH;
  // a slot being squashed never stalls, so the hazard is only raised in RUN
  assign w_hazard = i_valid && r_state == ST_RUN && i_ex_is_load && i_ex_rd_num != '0 &&
                    ((w_uses_rs_1 && i_ex_rd_num == w_rs_1_num) ||
                     (w_uses_rs_2 && i_ex_rd_num == w_rs_2_num));
  assign w_hold  = r_valid && !i_ex_ready;
  assign o_ready = !i_rst && !w_hold && !w_hazard;
  assign w_fire  = i_valid && o_ready && r_state == ST_RUN;
  assign w_eq    = w_rs_1 == w_rs_2;
  assign w_lt    = $signed(w_rs_1) < $signed(w_rs_2);
  assign w_ltu   = w_rs_1 < w_rs_2;
  assign w_cond  = (w_f3 == F3_BEQ)  ? w_eq  :
                   (w_f3 == F3_BNE)  ? !w_eq :
                   (w_f3 == F3_BLT)  ? w_lt  :
                   (w_f3 == F3_BGE)  ? !w_lt :
                   (w_f3 == F3_BLTU) ? w_ltu :
                   (w_f3 == F3_BGEU) ? !w_ltu : 1'b0;
  assign w_taken = w_op == JAL || w_op == JALR || (w_op == BRANCH && w_cond);
  assign w_b_pc  = (w_op == JALR) ? ((w_rs_1 + w_imm) & ~XLEN'(1)) : i_pc + w_imm;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    if (w_fire && w_taken) w_state_nxt = ST_SQUASH;
    else if (r_state == ST_SQUASH && o_ready) w_state_nxt = ST_RUN;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_rs_1    <= '0;
      r_rs_2    <= '0;
      r_imm     <= '0;
      r_rd_num  <= '0;
      r_opcode  <= '0;
      r_func_3  <= '0;
      r_func_7  <= '0;
      r_b_taken <= 1'b0;
      r_b_pc    <= '0;
    end else begin
      r_b_taken <= w_fire && w_taken;
      if (w_fire && w_taken) r_b_pc <= w_b_pc;
      if (!w_hold) begin
        r_valid  <= w_fire;
        r_rs_1   <= w_rs_1;
        r_rs_2   <= w_rs_2;
        r_imm    <= w_imm;
        r_rd_num <= REG_W'(i_inst[11:7]);
        r_opcode <= w_op;
        r_func_3 <= w_f3;
        r_func_7 <= i_inst[31:25];
      end
    end
  assign o_valid   = r_valid;
  assign o_rs_1    = r_rs_1;
  assign o_rs_2    = r_rs_2;
  assign o_imm     = r_imm;
  assign o_rd_num  = r_rd_num;
  assign o_opcode  = r_opcode;
  assign o_func_3  = r_func_3;
  assign o_func_7  = r_func_7;
  assign o_b_taken = r_b_taken;
  assign o_b_pc    = r_b_pc;
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised, registered successor to the combinational ID stage of the RV32I core.
- Contains:
  - instruction-field decode;
  - a unified sign-extended immediate generator;
  - an internal 2R1W register file;
  - load-use hazard detection with a stall handshake;
  - branch/jump resolution with a one-cycle wrong-path squash.
- Sits between the fetch stage (upstream) and the execute stage (downstream). Outputs come from an ID/EX pipeline register.

Parameters:
- XLEN, 32, data/PC width (32 or 64).
- REG_NUM, 32, architectural register count (16 for RV32E, 32 otherwise).
- REG_W, 5, register index width; must satisfy 2**REG_W >= REG_NUM.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_valid  in  1  fetch presents an instruction.
- i_inst  in  32  instruction word.
- i_pc  in  XLEN  PC of i_inst.
- o_ready  out  1  stage accepts i_inst this cycle.
- i_w_en  in  1  writeback enable.
- i_w_rd_num  in  REG_W  writeback register.
- i_w_rd  in  XLEN  writeback data.
- i_ex_ready  in  1  execute accepts the ID/EX register.
- i_ex_is_load  in  1  instruction currently in EX is a load.
- i_ex_rd_num  in  REG_W  rd of the instruction in EX.
- o_valid  out  1  ID/EX register holds a valid instruction.
- o_rs_1, o_rs_2  out  XLEN  operand values.
- o_rd_num  out  REG_W  destination register.
- o_opcode  out  7  opcode field.
- o_func_3  out  3  func_3 field.
- o_func_7  out  7  func_7 field.
- o_imm  out  XLEN  sign-extended immediate selected by opcode.
- o_b_taken  out  1  redirect pulse to fetch.
- o_b_pc  out  XLEN  redirect target.

Behaviour:
- Reset (asynchronous, i_rst=1): all outputs go to 0 (o_ready=0 during reset), squash flag cleared, all registers cleared. Register x0 reads 0 at all times; writes to x0 are ignored.
- Latency: one cycle. An instruction accepted at edge N appears on the o_* outputs after edge N (valid during cycle N+1).
- Handshake:
  - Accept when i_valid & o_ready.
  - Downstream transfer when o_valid & i_ex_ready.
  - When o_valid=1 and i_ex_ready=0, the ID/EX register holds and o_ready=0.
- Load-use hazard:
  - Detected when i_ex_is_load and i_ex_rd_num!=0 and i_ex_rd_num matches rs1 (R/I/S/B/JALR formats) or rs2 (R/S/B formats).
  - On detection, o_ready=0 and a bubble is loaded (o_valid=0 on the next cycle).
  - Stall lasts exactly as long as the condition holds.
- States:
  - RUN: normal operation.
  - SQUASH: entered for one cycle after a taken redirect. The instruction accepted in SQUASH is discarded (bubble) with o_ready=1, then the stage returns to RUN.
  - Reset returns to RUN and clears SQUASH.
- Branch resolution:
  - Evaluated from operand values read this cycle.
  - Covers BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR.
  - JALR target: (rs1+imm)&~1. Arithmetic is modulo 2**XLEN; PC wrap-around is silent.
  - o_b_taken is a registered one-cycle pulse issued together with the instruction's entry into ID/EX.
  - A stalled branch resolves only when it is accepted.
- Immediate generation:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All sign-extended to XLEN. Unknown opcode: imm=0, o_valid follows the handshake, no redirect.
- Simultaneous events:
  - Hazard and SQUASH together: the squash consumes the slot; the hazard is not flagged for a squashed instruction.
  - Writeback to the same register being read in the same cycle: see Optional Feature.
- Reset mid-stall or mid-squash aborts immediately; the first instruction after reset deasserts is accepted normally.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: read ports forward i_w_rd when i_w_en & i_w_rd_num==read index & index!=0, in the same cycle (write-through). Branch compare also uses the forwarded value.
- Undefined: reads return the pre-write register contents. The core must not read a register in the cycle it is written back.

Decomposition:
- Shared package decode_pkg:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - branch func_3 codes;
  - imm-format enum (IMM_I/S/B/U/J/NONE);
  - stage-state enum (ST_RUN, ST_SQUASH).
- One sub-module: regfile_2r1w, parametrised by XLEN/REG_NUM/REG_W. It owns x0 hardwiring and the bypass under the macro.

Test Plan:
- Reset, then write x5=0x0000_0010 via writeback; accept ADDI x6,x5,-1 (0xFFF28313) -> next cycle o_valid=1, o_rs_1=0x10, o_imm=0xFFFF_FFFF, o_rd_num=6.
- i_ex_is_load=1, i_ex_rd_num=5, i_inst=ADD x7,x5,x1 -> o_ready=0 and o_valid=0 for one cycle; after the load condition drops, ADD issues normally.
- x1=x2=3; BEQ x1,x2,+16 at pc 0x100 -> o_b_taken pulse, o_b_pc=0x110; next accepted instruction squashed (o_valid=0); the one after passes.
- i_ex_ready=0 with o_valid=1 for 3 cycles -> o_* held stable, o_ready=0; release -> transfer in 1 cycle.
- With DECODE_WB_BYPASS_EN: write x3=0xAA and read x3 same cycle -> o_rs_1=0xAA. Without the macro -> old value. Write to x0 -> reads remain 0.
- Assert i_rst in a stall cycle -> all outputs 0 immediately; XLEN=64 build: JAL with offset -4 from pc 0 -> o_b_pc=0xFFFF_FFFF_FFFF_FFFC.
